alu_seq: RTL and testbench

- Parametrised, registered successor to the datapath combinational ALU.
- Adds a start/done handshake, status flags, an illegal-opcode error and an iterative shift-add multiplier.
- Sits between the register-read stage and the writeback mux of the multi-cycle processor.
- The control FSM issues one operation at a time and waits for done before using out and the flags.

---
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_seq.sv | 183 ++++++++++++++++++
 tb/tb_alu_seq.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Operand/result bus between the processor control FSM (master) and alu_seq (slave).
// The master raises start with select/in1/in2 and waits for done before reading out and the flags.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       select;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;
  logic             zero;
  logic             neg;
  logic             carry;
  logic             ovf;
  logic             err;

  modport master (
    output start, select, in1, in2,
    input  out, busy, done, zero, neg, carry, ovf, err
  );

  modport slave (
    input  start, select, in1, in2,
    output out, busy, done, zero, neg, carry, ovf, err
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with a start/done handshake, status flags and an illegal-opcode error.
// Single-cycle ops complete on the accept edge; mul iterates shift-add for WIDTH cycles.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic   clk,
  input logic   rst_n,
  alu_seq_if.slave bus
);

  localparam int CW = SHW + 1;

  typedef enum logic {IDLE, MUL} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [2*WIDTH-1:0] mcand_reg, mcand_next;
  logic [WIDTH-1:0]   mplier_reg, mplier_next;
  logic [WIDTH-1:0]   out_reg, out_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               zero_reg, zero_next;
  logic               neg_reg, neg_next;
  logic               carry_reg, carry_next;
  logic               ovf_reg, ovf_next;
  logic               err_reg, err_next;

  // Single-cycle operation results, evaluated straight from the bus inputs
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   add_ext, sub_ext, shl_ext, shr_ext, sra_ext;
  logic [WIDTH-1:0] op_res;
  logic             op_carry, op_ovf, op_err;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    sh       = bus.in2[SHW-1:0];
    add_ext  = {1'b0, bus.in1} + {1'b0, bus.in2};
    sub_ext  = {1'b0, bus.in1} - {1'b0, bus.in2};
    // The extra bit beside the operand catches the last bit shifted out
    shl_ext  = {1'b0, bus.in1} << sh;
    shr_ext  = {bus.in1, 1'b0} >> sh;
    sra_ext  = $signed({bus.in1, 1'b0}) >>> sh;
    op_res   = '0;
    op_carry = 1'b0;
    op_ovf   = 1'b0;
    op_err   = 1'b0;
    case (bus.select)
      4'd0: begin
        op_res   = add_ext[WIDTH-1:0];
        op_carry = add_ext[WIDTH];
        op_ovf   = (bus.in1[WIDTH-1] == bus.in2[WIDTH-1]) &&
                   (op_res[WIDTH-1] != bus.in1[WIDTH-1]);
      end
      4'd1: begin
        op_res   = sub_ext[WIDTH-1:0];
        op_carry = sub_ext[WIDTH];
        op_ovf   = (bus.in1[WIDTH-1] != bus.in2[WIDTH-1]) &&
                   (op_res[WIDTH-1] != bus.in1[WIDTH-1]);
      end
      4'd2: op_res = bus.in1 & bus.in2;
      4'd3: op_res = bus.in1 | bus.in2;
      4'd4: op_res = bus.in1 ^ bus.in2;
      4'd5: op_res = ~bus.in1;
      4'd6: begin
        op_res   = shl_ext[WIDTH-1:0];
        op_carry = shl_ext[WIDTH];
      end
      4'd7: begin
        op_res   = sra_ext[WIDTH:1];
        op_carry = sra_ext[0];
      end
      4'd8: begin
        op_res   = shr_ext[WIDTH:1];
        op_carry = shr_ext[0];
      end
      default: op_err = 1'b1;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    out_next    = out_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    zero_next   = zero_reg;
    neg_next    = neg_reg;
    carry_next  = carry_reg;
    ovf_next    = ovf_reg;
    err_next    = err_reg;
    acc_step    = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          if (bus.select == 4'd9) begin
            mcand_next  = {{WIDTH{1'b0}}, bus.in1};
            mplier_next = bus.in2;
            acc_next    = '0;
            cnt_next    = CW'(WIDTH);
            busy_next   = 1'b1;
            state_next  = MUL;
          end else begin
            out_next   = op_res;
            carry_next = op_carry;
            ovf_next   = op_ovf;
            err_next   = op_err;
            done_next  = 1'b1;
          end
        end
      end
      MUL: begin
        acc_next    = acc_step;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg - 1'b1;
        if (cnt_reg == CW'(1)) begin
          out_next   = acc_step[WIDTH-1:0];
          carry_next = 1'b0;
          ovf_next   = |acc_step[2*WIDTH-1:WIDTH];
          err_next   = 1'b0;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Flags follow whatever out is about to become, only on a completion
    if (done_next) begin
      zero_next = (out_next == '0);
      neg_next  = out_next[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      out_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      zero_reg   <= 1'b0;
      neg_reg    <= 1'b0;
      carry_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      out_reg    <= out_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      zero_reg   <= zero_next;
      neg_reg    <= neg_next;
      carry_reg  <= carry_next;
      ovf_reg    <= ovf_next;
      err_reg    <= err_next;
    end
  end

  assign bus.out   = out_reg;
  assign bus.busy  = busy_reg;
  assign bus.done  = done_reg;
  assign bus.zero  = zero_reg;
  assign bus.neg   = neg_reg;
  assign bus.carry = carry_reg;
  assign bus.ovf   = ovf_reg;
  assign bus.err   = err_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32: vector table for single-cycle ops,
// hand-written sequences for back-to-back, multiply, ignored start and mid-multiply reset.
module tb_alu_seq;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  alu_seq_if #(.WIDTH(32)) bus ();

  alu_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e_out;
    logic        e_zero;
    logic        e_neg;
    logic        e_carry;
    logic        e_ovf;
    logic        e_err;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic [31:0] e_out, input logic e_zero,
                             input logic e_neg, input logic e_carry, input logic e_ovf,
                             input logic e_err);
    chk({tag, "_done"},  32'(bus.done),  32'd1);
    chk({tag, "_out"},   bus.out,        e_out);
    chk({tag, "_zero"},  32'(bus.zero),  32'(e_zero));
    chk({tag, "_neg"},   32'(bus.neg),   32'(e_neg));
    chk({tag, "_carry"}, 32'(bus.carry), 32'(e_carry));
    chk({tag, "_ovf"},   32'(bus.ovf),   32'(e_ovf));
    chk({tag, "_err"},   32'(bus.err),   32'(e_err));
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bus.start  = 1'b1;
    bus.select = v.sel;
    bus.in1    = v.a;
    bus.in2    = v.b;
    tick();
    bus.start = 1'b0;
    bus.in1   = 32'hDEAD_BEEF;
    check_flags($sformatf("vec%0d", idx), v.e_out, v.e_zero, v.e_neg, v.e_carry, v.e_ovf, v.e_err);
    $display("vec %0d sel=%0d a=%h b=%h out=%h z%0b n%0b c%0b v%0b e%0b", idx, v.sel, v.a, v.b,
             bus.out, bus.zero, bus.neg, bus.carry, bus.ovf, bus.err);
  endtask

  // Accepts a multiply, pokes start while busy, and expects done exactly 32 cycles later
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e_out, input logic e_zero, input logic e_ovf);
    logic [31:0] prev_out;
    int          bad;
    int          n;
    prev_out   = bus.out;
    bad        = 0;
    n          = 0;
    bus.start  = 1'b1;
    bus.select = 4'd9;
    bus.in1    = a;
    bus.in2    = b;
    tick();
    bus.start = 1'b0;
    bus.in1   = 32'h1234_5678;
    bus.in2   = 32'h0000_0003;
    chk({tag, "_busy_accept"}, 32'(bus.busy), 32'd1);
    for (int i = 1; i <= 40; i++) begin
      bus.start  = (i >= 3 && i <= 8) || (i == 20);
      bus.select = (i == 20) ? 4'd12 : 4'd0;
      tick();
      if (bus.done) begin
        n = i;
        break;
      end
      if (!bus.busy || bus.out !== prev_out) bad++;
    end
    bus.start = 1'b0;
    chk({tag, "_latency"},   32'(n), 32'd32);
    chk({tag, "_busy_hold"}, 32'(bad), 32'd0);
    chk({tag, "_busy_end"},  32'(bus.busy), 32'd0);
    check_flags(tag, e_out, e_zero, e_out[31], 1'b0, e_ovf, 1'b0);
    $display("mul %s a=%h b=%h cycles=%0d out=%h ovf=%0b", tag, a, b, n, bus.out, bus.ovf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    //            sel   a             b             out           z     n     c     v     e
    vecs[0]  = '{4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{4'd1,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{4'd7,  32'h80000010, 32'h00000024, 32'hF8000001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{4'd6,  32'h80000001, 32'h00000001, 32'h00000002, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{4'd8,  32'h80000010, 32'h00000005, 32'h04000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{4'd3,  32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{4'd4,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{4'd5,  32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{4'd12, 32'h12345678, 32'h87654321, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{4'd2,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{4'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{4'd6,  32'h12345678, 32'h00000020, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{4'd1,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{4'd15, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.select = 4'd0;
    bus.in1    = '0;
    bus.in2    = '0;
    tick();
    tick();
    chk("rst_out",  bus.out, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_flags", 32'({bus.zero, bus.neg, bus.carry, bus.ovf, bus.err}), 32'd0);
    #4 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    tick();
    chk("done_pulse_drop", 32'(bus.done), 32'd0);
    chk("out_hold", bus.out, 32'd0);

    // start held high: one result per cycle, done stays high
    bus.start = 1'b1;
    bus.select = 4'd0; bus.in1 = 32'd1;  bus.in2 = 32'd2;
    tick();
    chk("b2b0_done", 32'(bus.done), 32'd1);
    chk("b2b0_out", bus.out, 32'd3);
    bus.select = 4'd1; bus.in1 = 32'd10; bus.in2 = 32'd4;
    tick();
    chk("b2b1_done", 32'(bus.done), 32'd1);
    chk("b2b1_out", bus.out, 32'd6);
    bus.select = 4'd4; bus.in1 = 32'hF;  bus.in2 = 32'h3;
    tick();
    bus.start = 1'b0;
    chk("b2b2_done", 32'(bus.done), 32'd1);
    chk("b2b2_out", bus.out, 32'hC);
    $display("b2b out=%h", bus.out);
    tick();

    run_mul("mul0", 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 1'b0, 1'b0);
    tick();
    run_mul("mul1", 32'h80000000, 32'h00000002, 32'h00000000, 1'b1, 1'b1);
    tick();

    // give out a nonzero value so the reset clearing it is visible
    run_vec(100, '{4'd0, 32'h00000010, 32'h00000001, 32'h00000011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

    bus.start  = 1'b1;
    bus.select = 4'd9;
    bus.in1    = 32'h00001234;
    bus.in2    = 32'h00000010;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("abort_busy_before", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_out",  bus.out, 32'd0);
    tick();
    #4 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done || bus.busy) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    $display("abort out=%h busy=%0b", bus.out, bus.busy);

    run_vec(101, '{4'd0, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
